// File: rtl/spi_obi_pkg.sv
// rtl/spi_obi_pkg.sv - shared state, port-index and error-data definitions for the SPI/OBI arbiter
package spi_obi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef logic port_idx_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/spi_obi_rr_picker.sv
// rtl/spi_obi_rr_picker.sv - combinational 2-way round-robin selection
module spi_obi_rr_picker
  import spi_obi_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  prio,
  output logic       valid,
  output port_idx_t  idx
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) idx = prio;
    else              idx = req[1];
  end

endmodule

// File: rtl/spi_obi_arbiter.sv
// rtl/spi_obi_arbiter.sv - two-requester OBI arbiter with one outstanding transaction
// Optional response timeout enabled by defining ARB_TIMEOUT_EN.
module spi_obi_arbiter
  import spi_obi_pkg::*;
#(
  parameter int OBI_ADDR_WIDTH = 32,
  parameter int OBI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        obi_aclk,
  input  logic                        obi_areset,
  input  logic [1:0]                  s_req,
  output logic [1:0]                  s_gnt,
  input  logic [2*OBI_ADDR_WIDTH-1:0] s_addr,
  input  logic [1:0]                  s_we,
  input  logic [2*OBI_DATA_WIDTH-1:0] s_w_data,
  input  logic [7:0]                  s_be,
  output logic [1:0]                  s_r_valid,
  output logic [OBI_DATA_WIDTH-1:0]   s_r_data,
  output logic                        obi_master_req,
  input  logic                        obi_master_gnt,
  output logic [OBI_ADDR_WIDTH-1:0]   obi_master_addr,
  output logic                        obi_master_we,
  output logic [OBI_DATA_WIDTH-1:0]   obi_master_w_data,
  output logic [3:0]                  obi_master_be,
  input  logic                        obi_master_r_valid,
  input  logic [OBI_DATA_WIDTH-1:0]   obi_master_r_data,
  output logic                        busy,
  output logic                        owner,
  output logic                        timeout_err
);

  arb_state_e r_state;
  port_idx_t  r_owner;
  port_idx_t  r_prio;
  logic       r_busy;

  logic       w_pick_valid;
  port_idx_t  w_pick_idx;
  logic       w_in_addr;
  logic       w_in_resp;
  logic       w_own_req;
  logic       w_timeout;
  logic       w_rsp_done;

  spi_obi_rr_picker u_picker (
    .req   (s_req),
    .prio  (r_prio),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_in_addr  = (r_state == ST_ADDR);
  assign w_in_resp  = (r_state == ST_RESP);
  assign w_own_req  = s_req[r_owner];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_resp_cnt;

  // r_resp_cnt is the number of RESP cycles already elapsed, so the last allowed cycle sees TIMEOUT_CYCLES-1
  assign w_timeout = w_in_resp && !obi_master_r_valid &&
                     (r_resp_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge obi_aclk) begin
    if (obi_areset || !w_in_resp) r_resp_cnt <= '0;
    else                          r_resp_cnt <= r_resp_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_rsp_done = w_in_resp && (obi_master_r_valid || w_timeout);

  always_comb begin
    s_gnt     = 2'b00;
    s_r_valid = 2'b00;
    if (w_in_addr)  s_gnt[r_owner]     = obi_master_gnt;
    if (w_rsp_done) s_r_valid[r_owner] = 1'b1;
  end

  assign s_r_data          = w_timeout ? OBI_DATA_WIDTH'(ERR_RDATA) : obi_master_r_data;
  assign obi_master_req    = w_in_addr && w_own_req;
  assign obi_master_addr   = !w_in_addr ? '0 :
                             (r_owner ? s_addr[2*OBI_ADDR_WIDTH-1:OBI_ADDR_WIDTH]
                                      : s_addr[OBI_ADDR_WIDTH-1:0]);
  assign obi_master_w_data = !w_in_addr ? '0 :
                             (r_owner ? s_w_data[2*OBI_DATA_WIDTH-1:OBI_DATA_WIDTH]
                                      : s_w_data[OBI_DATA_WIDTH-1:0]);
  assign obi_master_be     = !w_in_addr ? 4'h0 : (r_owner ? s_be[7:4] : s_be[3:0]);
  assign obi_master_we     = w_in_addr && s_we[r_owner];

  assign busy        = r_busy;
  assign owner       = r_owner;
  assign timeout_err = w_timeout;

  always_ff @(posedge obi_aclk) begin
    if (obi_areset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_state <= ST_ADDR;
            r_busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          // a withdrawn request is abandoned without touching the priority pointer
          if (!w_own_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (obi_master_gnt) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_state <= ST_IDLE;
            r_prio  <= ~r_owner;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_obi_arbiter.md
SPI_OBI_ARBITER -- requirements
Module: spi_obi_arbiter

Interface
REQ-001 SHALL have parameter OBI_ADDR_WIDTH, 32, address width.
REQ-002 SHALL have parameter OBI_DATA_WIDTH, 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 255, response timeout limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-004 SHALL have port obi_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port obi_areset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_req  in  2  per-requester request; bit 0 is the SPI plug, bit 1 is the second master.
REQ-007 SHALL have port s_gnt  out  2  per-requester grant.
REQ-008 SHALL have port s_addr  in  2*OBI_ADDR_WIDTH  per-requester address, port n in slice n.
REQ-009 SHALL have port s_we  in  2  per-requester write enable.
REQ-010 SHALL have port s_w_data  in  2*OBI_DATA_WIDTH  per-requester write data.
REQ-011 SHALL have port s_be  in  2*4  per-requester byte enables.
REQ-012 SHALL have port s_r_valid  out  2  per-requester response valid.
REQ-013 SHALL have port s_r_data  out  OBI_DATA_WIDTH  response data, shared by both requesters.
REQ-014 SHALL have ports obi_master_req/gnt/addr/we/w_data/be/r_valid/r_data  out/in/out/out/out/out/in/in  with OBI widths; these form the single downstream OBI port.
REQ-015 SHALL have port busy  out  1  high when state is not IDLE.
REQ-016 SHALL have port owner  out  1  index of the current or last owner.
REQ-017 SHALL have port timeout_err  out  1  one-cycle pulse on a response timeout.

Function
REQ-018 SHALL implement an FSM with states IDLE, ADDR and RESP, and allow at most one outstanding transaction.
REQ-019 IDLE: on any s_req, SHALL register the winner into owner and go to ADDR next cycle; no master req is driven in IDLE.
REQ-020 Arbitration SHALL be 2-way round-robin:
  - a lone request wins;
  - if both request, the port selected by priority pointer prio wins.
REQ-021 ADDR: obi_master_req SHALL equal s_req[owner], and addr/we/w_data/be SHALL be muxed from owner.
  - s_gnt[owner] SHALL equal obi_master_gnt; s_gnt of the other port SHALL be 0.
REQ-022 ADDR: on master req&&gnt SHALL go to RESP.
  - If s_req[owner] drops before gnt, SHALL return to IDLE with prio unchanged.
REQ-023 RESP: s_r_valid[owner] SHALL equal obi_master_r_valid; s_r_data SHALL equal obi_master_r_data.
  - On r_valid SHALL go to IDLE and set prio to the other port.
REQ-024 In IDLE and RESP, obi_master_req SHALL be 0 and all s_gnt SHALL be 0.
  - r_valid arriving outside RESP SHALL be ignored.
REQ-025 Grant latency SHALL be at least 1 cycle after s_req rises (IDLE->ADDR register stage).
  - Back-to-back transactions SHALL pass through IDLE for one cycle.
REQ-026 A request present in IDLE while the other port was just served SHALL win within one arbitration, i.e. no starvation.

Reset
REQ-027 With obi_areset high at a clock edge, the block SHALL apply the following on that edge:
  - state=IDLE, prio=0, owner=0;
  - all s_gnt, s_r_valid, obi_master_req, busy and timeout_err = 0;
  - master addr/w_data/be/we = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it.
  - A late r_valid after reset SHALL be ignored.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: a counter SHALL count cycles in RESP.
  - On reaching TIMEOUT_CYCLES without r_valid, the block SHALL pulse s_r_valid[owner] and timeout_err for 1 cycle with s_r_data=32'hDEADBEEF.
  - It SHALL then go to IDLE and update prio as for a normal response.
REQ-030 Macro ARB_TIMEOUT_EN undefined: there SHALL be no counter, RESP SHALL wait indefinitely, and timeout_err SHALL be tied 0.

Structure
REQ-031 Package spi_obi_pkg SHALL hold the FSM state enum, the 1-bit port index typedef and the DEADBEEF error-data constant.
REQ-032 Sub-module spi_obi_rr_picker SHALL implement the combinational 2-input round-robin selection (inputs req and prio; outputs valid and idx).

Verification
REQ-033 Bench SHALL cover single request: s_req=01 with addr 0x1000 and we=0; gnt after 2 cycles; r_data=0x12345678 -> s_r_valid[0] pulse, s_r_data=0x12345678, prio=1.
REQ-034 Bench SHALL cover contention: s_req=11 from reset -> port 0 served first, then port 1, then port 0 again; order 0,1,0 on owner.
REQ-035 Bench SHALL cover gnt stall: master gnt low for 5 cycles in ADDR -> master req, addr and be stable, and s_gnt stays 0 throughout.
REQ-036 Bench SHALL cover a write from port 1: we=1, w_data=0xCAFEF00D, be=4'b1111 -> master sees exactly these values; s_gnt[0] stays 0.
REQ-037 Bench SHALL cover reset in RESP: assert obi_areset, then r_valid arrives -> no s_r_valid, state IDLE, prio=0.
REQ-038 Bench SHALL cover timeout with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no r_valid -> at cycle 8, timeout_err=1, s_r_data=0xDEADBEEF, next state IDLE.
